// File: rtl/id_ex_stage_pkg.sv
// Shared types and encodings for the ID/EX pipeline register and operand-bypass stage.
// ALU operand-B source select, forwarding-path select, the registered control
// bundle, and a saturating increment for the optional hazard counters
// (enabled by ID_EX_HAZARD_STATS_EN).
package id_ex_stage_pkg;

  localparam int SHAMT_W  = 5;
  localparam int ALU_OP_W = 6;
  localparam int STAT_W   = 16;

  typedef enum logic [1:0] {
    SRC_B_RT    = 2'd0,
    SRC_B_IMM   = 2'd1,
    SRC_B_SHAMT = 2'd2,
    SRC_B_RSVD  = 2'd3
  } src_b_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0] aluOp;
    logic                regWr;
    logic                memRd;
    logic                memWr;
  } ctrl_t;

  function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] value);
    return (value == {STAT_W{1'b1}}) ? value : value + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between ID, the ID/EX stage, the later pipeline stages and the ALU.
// master = surrounding pipeline, slave = id_ex_stage.
// The hazard counter outputs exist only with ID_EX_HAZARD_STATS_EN defined.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
);

  logic                valid_id_i;
  logic [DW-1:0]       rs_data_id_i;
  logic [DW-1:0]       rt_data_id_i;
  logic [DW-1:0]       imm_id_i;
  logic [SHAMT_W-1:0]  shamt_id_i;
  logic [AW-1:0]       rs_addr_id_i;
  logic [AW-1:0]       rt_addr_id_i;
  logic [AW-1:0]       rd_addr_id_i;
  logic                use_rs_id_i;
  logic                use_rt_id_i;
  logic [1:0]          src_b_sel_id_i;
  logic [ALU_OP_W-1:0] alu_op_id_i;
  logic                reg_wr_id_i;
  logic                mem_rd_id_i;
  logic                mem_wr_id_i;
  logic                reg_wr_mem_i;
  logic [AW-1:0]       rd_addr_mem_i;
  logic [DW-1:0]       res_mem_i;
  logic                reg_wr_wb_i;
  logic [AW-1:0]       rd_addr_wb_i;
  logic [DW-1:0]       res_wb_i;
  logic                ex_stall_i;
  logic                flush_i;
  logic                stall_id_o;
  logic                valid_ex_o;
  logic [DW-1:0]       opr_a_ex_o;
  logic [DW-1:0]       opr_b_ex_o;
  logic [DW-1:0]       st_data_ex_o;
  logic [ALU_OP_W-1:0] alu_op_ex_o;
  logic [AW-1:0]       rd_addr_ex_o;
  logic                reg_wr_ex_o;
  logic                mem_rd_ex_o;
  logic                mem_wr_ex_o;
`ifdef ID_EX_HAZARD_STATS_EN
  logic [STAT_W-1:0]   fwd_cnt_o;
  logic [STAT_W-1:0]   lu_stall_cnt_o;
`endif

  modport master (
    output valid_id_i, rs_data_id_i, rt_data_id_i, imm_id_i, shamt_id_i,
           rs_addr_id_i, rt_addr_id_i, rd_addr_id_i, use_rs_id_i, use_rt_id_i,
           src_b_sel_id_i, alu_op_id_i, reg_wr_id_i, mem_rd_id_i, mem_wr_id_i,
           reg_wr_mem_i, rd_addr_mem_i, res_mem_i,
           reg_wr_wb_i, rd_addr_wb_i, res_wb_i,
           ex_stall_i, flush_i,
    input  stall_id_o, valid_ex_o, opr_a_ex_o, opr_b_ex_o, st_data_ex_o,
           alu_op_ex_o, rd_addr_ex_o, reg_wr_ex_o, mem_rd_ex_o, mem_wr_ex_o
`ifdef ID_EX_HAZARD_STATS_EN
    , input fwd_cnt_o, lu_stall_cnt_o
`endif
  );

  modport slave (
    input  valid_id_i, rs_data_id_i, rt_data_id_i, imm_id_i, shamt_id_i,
           rs_addr_id_i, rt_addr_id_i, rd_addr_id_i, use_rs_id_i, use_rt_id_i,
           src_b_sel_id_i, alu_op_id_i, reg_wr_id_i, mem_rd_id_i, mem_wr_id_i,
           reg_wr_mem_i, rd_addr_mem_i, res_mem_i,
           reg_wr_wb_i, rd_addr_wb_i, res_wb_i,
           ex_stall_i, flush_i,
    output stall_id_o, valid_ex_o, opr_a_ex_o, opr_b_ex_o, st_data_ex_o,
           alu_op_ex_o, rd_addr_ex_o, reg_wr_ex_o, mem_rd_ex_o, mem_wr_ex_o
`ifdef ID_EX_HAZARD_STATS_EN
    , output fwd_cnt_o, lu_stall_cnt_o
`endif
  );

endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// Forwarding selector for one EX operand (fwd_sel): compares the operand's register
// number against the EX/MEM and MEM/WB destinations and muxes in the youngest
// matching result. EX/MEM wins over MEM/WB, and $0 is never forwarded.
// hit_o exists only with ID_EX_HAZARD_STATS_EN defined.
module id_ex_stage_fwd_sel
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] src_addr_i,
  input  logic [DW-1:0] reg_data_i,
  input  logic          reg_wr_mem_i,
  input  logic [AW-1:0] rd_addr_mem_i,
  input  logic [DW-1:0] res_mem_i,
  input  logic          reg_wr_wb_i,
  input  logic [AW-1:0] rd_addr_wb_i,
  input  logic [DW-1:0] res_wb_i,
  output logic [DW-1:0] data_o
`ifdef ID_EX_HAZARD_STATS_EN
  , output logic        hit_o
`endif
);

  logic memHit;
  logic wbHit;
  fwd_e sel;

  // Address compare against each later stage's destination; $0 never matches
  always_comb begin
    memHit = reg_wr_mem_i && (rd_addr_mem_i == src_addr_i) && (src_addr_i != '0);
    wbHit  = reg_wr_wb_i  && (rd_addr_wb_i  == src_addr_i) && (src_addr_i != '0);
  end

  // Priority pick: the younger EX/MEM result shadows MEM/WB
  always_comb begin
    sel = FWD_NONE;
    if (memHit) begin
      sel = FWD_MEM;
    end else if (wbHit) begin
      sel = FWD_WB;
    end
  end

  // Operand mux driven by the chosen path
  always_comb begin
    data_o = reg_data_i;
    case (sel)
      FWD_MEM: data_o = res_mem_i;
      FWD_WB:  data_o = res_wb_i;
      default: data_o = reg_data_i;
    endcase
  end

`ifdef ID_EX_HAZARD_STATS_EN
  assign hit_o = (sel != FWD_NONE);
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and operand-bypass stage feeding the ALU.
// Registers decoded operands/control, forwards EX/MEM and MEM/WB results onto the
// registered operands, selects ALU operand B and detects load-use hazards.
// Optional feature macro: ID_EX_HAZARD_STATS_EN adds forward/load-use counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  logic               valid_q,  valid_d;
  ctrl_t              ctrl_q,   ctrl_d;
  logic [AW-1:0]      rsAddr_q, rsAddr_d;
  logic [AW-1:0]      rtAddr_q, rtAddr_d;
  logic [AW-1:0]      rdAddr_q, rdAddr_d;
  logic [DW-1:0]      rsData_q, rsData_d;
  logic [DW-1:0]      rtData_q, rtData_d;
  logic [DW-1:0]      imm_q,    imm_d;
  logic [SHAMT_W-1:0] shamt_q,  shamt_d;
  src_b_e             srcB_q,   srcB_d;

  logic [DW-1:0]      rsFwd;
  logic [DW-1:0]      rtFwd;
  logic               loadUse;

`ifdef ID_EX_HAZARD_STATS_EN
  logic               rsHit;
  logic               rtHit;
  logic [STAT_W-1:0]  fwdCnt_q, fwdCnt_d;
  logic [STAT_W-1:0]  luCnt_q,  luCnt_d;
`endif

  id_ex_stage_fwd_sel #(.DW(DW), .AW(AW)) u_fwd_rs (
    .src_addr_i    (rsAddr_q),
    .reg_data_i    (rsData_q),
    .reg_wr_mem_i  (bus.reg_wr_mem_i),
    .rd_addr_mem_i (bus.rd_addr_mem_i),
    .res_mem_i     (bus.res_mem_i),
    .reg_wr_wb_i   (bus.reg_wr_wb_i),
    .rd_addr_wb_i  (bus.rd_addr_wb_i),
    .res_wb_i      (bus.res_wb_i),
    .data_o        (rsFwd)
`ifdef ID_EX_HAZARD_STATS_EN
    , .hit_o       (rsHit)
`endif
  );

  id_ex_stage_fwd_sel #(.DW(DW), .AW(AW)) u_fwd_rt (
    .src_addr_i    (rtAddr_q),
    .reg_data_i    (rtData_q),
    .reg_wr_mem_i  (bus.reg_wr_mem_i),
    .rd_addr_mem_i (bus.rd_addr_mem_i),
    .res_mem_i     (bus.res_mem_i),
    .reg_wr_wb_i   (bus.reg_wr_wb_i),
    .rd_addr_wb_i  (bus.rd_addr_wb_i),
    .res_wb_i      (bus.res_wb_i),
    .data_o        (rtFwd)
`ifdef ID_EX_HAZARD_STATS_EN
    , .hit_o       (rtHit)
`endif
  );

  // Load in EX whose destination is read by the instruction waiting in ID
  always_comb begin
    loadUse = valid_q && ctrl_q.memRd && (rdAddr_q != '0) && bus.valid_id_i &&
              ((bus.use_rs_id_i && (bus.rs_addr_id_i == rdAddr_q)) ||
               (bus.use_rt_id_i && (bus.rt_addr_id_i == rdAddr_q)));
    bus.stall_id_o = bus.ex_stall_i || loadUse;
  end

  // Next-state priority: flush, downstream hold (with operand refresh), bubble, capture
  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    rsAddr_d = rsAddr_q;
    rtAddr_d = rtAddr_q;
    rdAddr_d = rdAddr_q;
    rsData_d = rsData_q;
    rtData_d = rtData_q;
    imm_d    = imm_q;
    shamt_d  = shamt_q;
    srcB_d   = srcB_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (bus.ex_stall_i) begin
      rsData_d = rsFwd;
      rtData_d = rtFwd;
    end else if (loadUse) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else begin
      valid_d  = bus.valid_id_i;
      ctrl_d   = '{aluOp: bus.alu_op_id_i, regWr: bus.reg_wr_id_i,
                   memRd: bus.mem_rd_id_i, memWr: bus.mem_wr_id_i};
      rsAddr_d = bus.rs_addr_id_i;
      rtAddr_d = bus.rt_addr_id_i;
      rdAddr_d = bus.rd_addr_id_i;
      rsData_d = bus.rs_data_id_i;
      rtData_d = bus.rt_data_id_i;
      imm_d    = bus.imm_id_i;
      shamt_d  = bus.shamt_id_i;
      srcB_d   = src_b_e'(bus.src_b_sel_id_i);
    end
  end

  // Stage registers with synchronous reset to all zero
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      rsAddr_q <= '0;
      rtAddr_q <= '0;
      rdAddr_q <= '0;
      rsData_q <= '0;
      rtData_q <= '0;
      imm_q    <= '0;
      shamt_q  <= '0;
      srcB_q   <= SRC_B_RT;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      rsAddr_q <= rsAddr_d;
      rtAddr_q <= rtAddr_d;
      rdAddr_q <= rdAddr_d;
      rsData_q <= rsData_d;
      rtData_q <= rtData_d;
      imm_q    <= imm_d;
      shamt_q  <= shamt_d;
      srcB_q   <= srcB_d;
    end
  end

  // EX outputs: forwarded operands, B-source select, controls gated by valid
  always_comb begin
    bus.valid_ex_o   = valid_q;
    bus.opr_a_ex_o   = rsFwd;
    bus.st_data_ex_o = rtFwd;
    bus.alu_op_ex_o  = ctrl_q.aluOp;
    bus.rd_addr_ex_o = rdAddr_q;
    bus.reg_wr_ex_o  = valid_q && ctrl_q.regWr;
    bus.mem_rd_ex_o  = valid_q && ctrl_q.memRd;
    bus.mem_wr_ex_o  = valid_q && ctrl_q.memWr;
    case (srcB_q)
      SRC_B_IMM:   bus.opr_b_ex_o = imm_q;
      SRC_B_SHAMT: bus.opr_b_ex_o = {{(DW-SHAMT_W){1'b0}}, shamt_q};
      default:     bus.opr_b_ex_o = rtFwd;
    endcase
  end

`ifdef ID_EX_HAZARD_STATS_EN
  // Saturating hazard counters, frozen while the downstream hold is active
  always_comb begin
    fwdCnt_d = fwdCnt_q;
    luCnt_d  = luCnt_q;
    if (!bus.ex_stall_i) begin
      if (valid_q && (rsHit || rtHit)) begin
        fwdCnt_d = satInc(fwdCnt_q);
      end
      if (!bus.flush_i && loadUse) begin
        luCnt_d = satInc(luCnt_q);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fwdCnt_q <= '0;
      luCnt_q  <= '0;
    end else begin
      fwdCnt_q <= fwdCnt_d;
      luCnt_q  <= luCnt_d;
    end
  end

  assign bus.fwd_cnt_o      = fwdCnt_q;
  assign bus.lu_stall_cnt_o = luCnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the EX slot.
// Counter checks are included when ID_EX_HAZARD_STATS_EN is defined.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        valid;
    logic [4:0]  rsA;
    logic [4:0]  rtA;
    logic [4:0]  rd;
    logic [31:0] rsD;
    logic [31:0] rtD;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [1:0]  sel;
    logic [5:0]  op;
    logic        regWr;
    logic        memRd;
    logic        memWr;
  } exEntry_t;

  exEntry_t ex;
  bit dataKnown;
  int unsigned modelFwdCnt;
  int unsigned modelLuCnt;

  id_ex_stage_if #(.DW(32), .AW(5)) bus ();

  id_ex_stage #(.DW(32), .AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Value a later stage would bypass to register a, or v if nothing matches
  function automatic logic [31:0] bypass(input logic [4:0] a, input logic [31:0] v);
    if (a != 5'd0 && bus.reg_wr_mem_i && bus.rd_addr_mem_i == a) return bus.res_mem_i;
    if (a != 5'd0 && bus.reg_wr_wb_i  && bus.rd_addr_wb_i  == a) return bus.res_wb_i;
    return v;
  endfunction

  function automatic bit forwarded(input logic [4:0] a);
    return (a != 5'd0) && ((bus.reg_wr_mem_i && bus.rd_addr_mem_i == a) ||
                           (bus.reg_wr_wb_i  && bus.rd_addr_wb_i  == a));
  endfunction

  function automatic bit loadUseNow();
    return ex.valid && ex.memRd && ex.rd != 5'd0 && bus.valid_id_i &&
           ((bus.use_rs_id_i && bus.rs_addr_id_i == ex.rd) ||
            (bus.use_rt_id_i && bus.rt_addr_id_i == ex.rd));
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] expB;
    checkVal("valid_ex", bus.valid_ex_o, ex.valid);
    checkVal("stall_id", bus.stall_id_o, bus.ex_stall_i || loadUseNow());
    checkVal("reg_wr_ex", bus.reg_wr_ex_o, ex.valid && ex.regWr);
    checkVal("mem_rd_ex", bus.mem_rd_ex_o, ex.valid && ex.memRd);
    checkVal("mem_wr_ex", bus.mem_wr_ex_o, ex.valid && ex.memWr);
    if (ex.valid || dataKnown) begin
      if (ex.sel == 2'd1)      expB = ex.imm;
      else if (ex.sel == 2'd2) expB = {27'd0, ex.shamt};
      else                     expB = bypass(ex.rtA, ex.rtD);
      checkVal("opr_a", bus.opr_a_ex_o, bypass(ex.rsA, ex.rsD));
      checkVal("opr_b", bus.opr_b_ex_o, expB);
      checkVal("st_data", bus.st_data_ex_o, bypass(ex.rtA, ex.rtD));
      checkVal("alu_op", bus.alu_op_ex_o, ex.op);
      checkVal("rd_addr", bus.rd_addr_ex_o, ex.rd);
    end
`ifdef ID_EX_HAZARD_STATS_EN
    checkVal("fwd_cnt", bus.fwd_cnt_o, modelFwdCnt);
    checkVal("lu_cnt", bus.lu_stall_cnt_o, modelLuCnt);
`endif
  endtask

  // Advance the model one clock according to the stage's update rules
  task automatic modelUpdate();
`ifdef ID_EX_HAZARD_STATS_EN
    bit fwdNow = ex.valid && (forwarded(ex.rsA) || forwarded(ex.rtA));
    bit luNow  = loadUseNow();
    if (reset) begin
      modelFwdCnt = 0;
      modelLuCnt  = 0;
    end else if (!bus.ex_stall_i) begin
      if (fwdNow && modelFwdCnt < 32'hFFFF) modelFwdCnt++;
      if (!bus.flush_i && luNow && modelLuCnt < 32'hFFFF) modelLuCnt++;
    end
`endif
    if (reset) begin
      ex = '{default: '0};
      dataKnown = 1'b1;
    end else if (bus.flush_i) begin
      ex.valid = 1'b0; ex.regWr = 1'b0; ex.memRd = 1'b0; ex.memWr = 1'b0;
      dataKnown = 1'b0;
    end else if (bus.ex_stall_i) begin
      ex.rsD = bypass(ex.rsA, ex.rsD);
      ex.rtD = bypass(ex.rtA, ex.rtD);
    end else if (loadUseNow()) begin
      ex.valid = 1'b0; ex.regWr = 1'b0; ex.memRd = 1'b0; ex.memWr = 1'b0;
      dataKnown = 1'b0;
    end else begin
      ex.valid = bus.valid_id_i;
      ex.rsA = bus.rs_addr_id_i;  ex.rtA = bus.rt_addr_id_i;  ex.rd = bus.rd_addr_id_i;
      ex.rsD = bus.rs_data_id_i;  ex.rtD = bus.rt_data_id_i;
      ex.imm = bus.imm_id_i;      ex.shamt = bus.shamt_id_i;  ex.sel = bus.src_b_sel_id_i;
      ex.op = bus.alu_op_id_i;    ex.regWr = bus.reg_wr_id_i;
      ex.memRd = bus.mem_rd_id_i; ex.memWr = bus.mem_wr_id_i;
      dataKnown = 1'b1;
    end
  endtask

  // Check on the falling edge, advance the model, then move past the rising edge
  task automatic step();
    @(negedge clk);
    checkOutput();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rsA, input logic [31:0] rsD,
                               input logic [4:0] rtA, input logic [31:0] rtD, input logic [4:0] rd,
                               input logic uRs, input logic uRt, input logic [1:0] sel,
                               input logic [5:0] op, input logic rw, input logic mr, input logic mw);
    bus.valid_id_i = v;
    bus.rs_addr_id_i = rsA;  bus.rs_data_id_i = rsD;
    bus.rt_addr_id_i = rtA;  bus.rt_data_id_i = rtD;
    bus.rd_addr_id_i = rd;
    bus.use_rs_id_i = uRs;   bus.use_rt_id_i = uRt;
    bus.src_b_sel_id_i = sel; bus.alu_op_id_i = op;
    bus.reg_wr_id_i = rw;    bus.mem_rd_id_i = mr;  bus.mem_wr_id_i = mw;
  endtask

  task automatic idleBypass();
    bus.reg_wr_mem_i = 1'b0; bus.rd_addr_mem_i = 5'd0; bus.res_mem_i = 32'd0;
    bus.reg_wr_wb_i  = 1'b0; bus.rd_addr_wb_i  = 5'd0; bus.res_wb_i  = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    bus.imm_id_i = 32'd0; bus.shamt_id_i = 5'd0;
    bus.ex_stall_i = 1'b0; bus.flush_i = 1'b0;
    idleBypass();
    repeat (2) @(posedge clk);
    #1;
    ex = '{default: '0};
    dataKnown = 1'b1;
    modelFwdCnt = 0;
    modelLuCnt  = 0;

    // Reset state
    step();
    checkVal("rst_valid", bus.valid_ex_o, 32'd0);
    checkVal("rst_stall", bus.stall_id_o, 32'd0);
    checkVal("rst_opr_a", bus.opr_a_ex_o, 32'd0);

    // No hazard: add r7 = r5 + r6
    reset = 1'b0;
    applyStimulus(1'b1, 5'd5, 32'h10, 5'd6, 32'h20, 5'd7, 1'b1, 1'b1, 2'd0, 6'h20, 1'b1, 1'b0, 1'b0);
    step();
    checkVal("nohaz_valid", bus.valid_ex_o, 32'd1);
    checkVal("nohaz_opr_a", bus.opr_a_ex_o, 32'h10);
    checkVal("nohaz_opr_b", bus.opr_b_ex_o, 32'h20);
    checkVal("nohaz_stall", bus.stall_id_o, 32'd0);

    // Double forward on r5, then WB only
    bus.valid_id_i = 1'b0;
    bus.reg_wr_mem_i = 1'b1; bus.rd_addr_mem_i = 5'd5; bus.res_mem_i = 32'hAAAA;
    bus.reg_wr_wb_i  = 1'b1; bus.rd_addr_wb_i  = 5'd5; bus.res_wb_i  = 32'hBBBB;
    #1;
    checkVal("dfwd_mem", bus.opr_a_ex_o, 32'hAAAA);
    bus.reg_wr_mem_i = 1'b0;
    #1;
    checkVal("dfwd_wb", bus.opr_a_ex_o, 32'hBBBB);

    // $0 source never forwarded
    applyStimulus(1'b1, 5'd0, 32'h55, 5'd6, 32'h20, 5'd7, 1'b1, 1'b1, 2'd0, 6'h20, 1'b1, 1'b0, 1'b0);
    step();
    bus.reg_wr_mem_i = 1'b1; bus.rd_addr_mem_i = 5'd0; bus.res_mem_i = 32'hDEAD;
    bus.reg_wr_wb_i  = 1'b1; bus.rd_addr_wb_i  = 5'd0; bus.res_wb_i  = 32'hDEAD;
    #1;
    checkVal("zero_nofwd", bus.opr_a_ex_o, 32'h55);
    idleBypass();

    // Load-use: lw r8, then an instruction reading r8
    applyStimulus(1'b1, 5'd1, 32'h11, 5'd2, 32'h22, 5'd8, 1'b1, 1'b0, 2'd1, 6'h23, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 5'd8, 32'h0, 5'd3, 32'h33, 5'd9, 1'b1, 1'b1, 2'd0, 6'h20, 1'b1, 1'b0, 1'b0);
    #1;
    checkVal("lu_stall", bus.stall_id_o, 32'd1);
    step();
    checkVal("lu_bubble", bus.valid_ex_o, 32'd0);
    checkVal("lu_release", bus.stall_id_o, 32'd0);
    step();
    checkVal("lu_enter", bus.valid_ex_o, 32'd1);
    checkVal("lu_nostall", bus.stall_id_o, 32'd0);

    // Hold refresh: WB forwards r9 only during the first held cycle
    applyStimulus(1'b1, 5'd9, 32'h1, 5'd3, 32'h33, 5'd10, 1'b1, 1'b1, 2'd0, 6'h20, 1'b1, 1'b0, 1'b0);
    step();
    bus.valid_id_i = 1'b0;
    bus.ex_stall_i = 1'b1;
    bus.reg_wr_wb_i = 1'b1; bus.rd_addr_wb_i = 5'd9; bus.res_wb_i = 32'h1234;
    #1;
    checkVal("hold_stall", bus.stall_id_o, 32'd1);
    step();
    idleBypass();
    step();
    step();
    bus.ex_stall_i = 1'b0;
    #1;
    checkVal("hold_opr_a", bus.opr_a_ex_o, 32'h1234);
    checkVal("hold_valid", bus.valid_ex_o, 32'd1);

    // Flush beats stall
    applyStimulus(1'b1, 5'd1, 32'h5, 5'd2, 32'h6, 5'd11, 1'b1, 1'b1, 2'd0, 6'h2B, 1'b1, 1'b1, 1'b1);
    step();
    bus.flush_i = 1'b1; bus.ex_stall_i = 1'b1;
    step();
    checkVal("flush_valid", bus.valid_ex_o, 32'd0);
    checkVal("flush_reg_wr", bus.reg_wr_ex_o, 32'd0);
    checkVal("flush_mem_rd", bus.mem_rd_ex_o, 32'd0);
    checkVal("flush_mem_wr", bus.mem_wr_ex_o, 32'd0);
    bus.flush_i = 1'b0; bus.ex_stall_i = 1'b0;

    // Reset during a load-use stall
    applyStimulus(1'b1, 5'd1, 32'h11, 5'd2, 32'h22, 5'd8, 1'b1, 1'b0, 2'd1, 6'h23, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 5'd8, 32'h0, 5'd3, 32'h33, 5'd9, 1'b1, 1'b1, 2'd0, 6'h20, 1'b1, 1'b0, 1'b0);
    #1;
    checkVal("rstmid_pre", bus.stall_id_o, 32'd1);
    reset = 1'b1;
    step();
    checkVal("rstmid_valid", bus.valid_ex_o, 32'd0);
    checkVal("rstmid_stall", bus.stall_id_o, 32'd0);
    checkVal("rstmid_opr_a", bus.opr_a_ex_o, 32'd0);
    checkVal("rstmid_opr_b", bus.opr_b_ex_o, 32'd0);
    checkVal("rstmid_alu_op", bus.alu_op_ex_o, 32'd0);
    checkVal("rstmid_rd", bus.rd_addr_ex_o, 32'd0);
`ifdef ID_EX_HAZARD_STATS_EN
    checkVal("rstmid_fwd_cnt", bus.fwd_cnt_o, 32'd0);
    checkVal("rstmid_lu_cnt", bus.lu_stall_cnt_o, 32'd0);
`endif
    reset = 1'b0;

    // Random traffic with a small register space to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      bus.flush_i    = ($urandom_range(0, 9) == 0);
      bus.ex_stall_i = ($urandom_range(0, 5) == 0);
      bus.valid_id_i = ($urandom_range(0, 3) != 0);
      bus.rs_addr_id_i = 5'($urandom_range(0, 3));
      bus.rt_addr_id_i = 5'($urandom_range(0, 3));
      bus.rd_addr_id_i = 5'($urandom_range(0, 3));
      bus.rs_data_id_i = $urandom;
      bus.rt_data_id_i = $urandom;
      bus.imm_id_i     = $urandom;
      bus.shamt_id_i   = 5'($urandom);
      bus.use_rs_id_i  = 1'($urandom);
      bus.use_rt_id_i  = 1'($urandom);
      bus.src_b_sel_id_i = 2'($urandom);
      bus.alu_op_id_i  = 6'($urandom);
      bus.reg_wr_id_i  = 1'($urandom);
      bus.mem_rd_id_i  = 1'($urandom);
      bus.mem_wr_id_i  = 1'($urandom);
      bus.reg_wr_mem_i  = 1'($urandom);
      bus.rd_addr_mem_i = 5'($urandom_range(0, 3));
      bus.res_mem_i     = $urandom;
      bus.reg_wr_wb_i   = 1'($urandom);
      bus.rd_addr_wb_i  = 5'($urandom_range(0, 3));
      bus.res_wb_i      = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and operand-bypass stage that feeds the ALU in the MIPS pipeline.
- Captures decoded operands and control from ID.
- Resolves EX/MEM and MEM/WB forwarding combinationally on its outputs.
- Selects ALU operand B (rt / immediate / shamt).
- Detects load-use hazards and stalls ID while inserting a bubble into EX.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_id_i  in  1  ID holds a valid instruction.
- rs_data_id_i  in  DW  register-file rs value.
- rt_data_id_i  in  DW  register-file rt value.
- imm_id_i  in  DW  extended immediate.
- shamt_id_i  in  5  shift amount.
- rs_addr_id_i  in  AW  rs number.
- rt_addr_id_i  in  AW  rt number.
- rd_addr_id_i  in  AW  destination number.
- use_rs_id_i  in  1  instruction reads rs.
- use_rt_id_i  in  1  instruction reads rt.
- src_b_sel_id_i  in  2  B source: 0=rt, 1=imm, 2=shamt (zero-extended), 3=reserved (treated as rt).
- alu_op_id_i  in  6  ALU opcode.
- reg_wr_id_i  in  1  writes rd.
- mem_rd_id_i  in  1  load.
- mem_wr_id_i  in  1  store.
- reg_wr_mem_i  in  1  EX/MEM writes a register.
- rd_addr_mem_i  in  AW  EX/MEM destination.
- res_mem_i  in  DW  EX/MEM result.
- reg_wr_wb_i  in  1  MEM/WB writes a register.
- rd_addr_wb_i  in  AW  MEM/WB destination.
- res_wb_i  in  DW  MEM/WB result.
- ex_stall_i  in  1  downstream hold.
- flush_i  in  1  kill EX contents (branch redirect).
- stall_id_o  out  1  hold PC/IF/ID (load-use).
- valid_ex_o  out  1  EX holds a valid instruction.
- opr_a_ex_o  out  DW  forwarded rs to ALU A.
- opr_b_ex_o  out  DW  selected/forwarded ALU B.
- st_data_ex_o  out  DW  forwarded rt (store data).
- alu_op_ex_o  out  6  ALU opcode.
- rd_addr_ex_o  out  AW  destination.
- reg_wr_ex_o  out  1  register write, gated by valid.
- mem_rd_ex_o  out  1  load, gated by valid.
- mem_wr_ex_o  out  1  store, gated by valid.

Behaviour:
- Reset: all stage registers are 0.
  - valid_ex_o=0, alu_op_ex_o=0, rd_addr_ex_o=0, all control outputs 0, stall_id_o=0.
  - Data outputs are 0.
- Latency: one cycle from ID capture to EX outputs. Forwarding and operand selection are combinational on the registered values.
- Forwarding, per operand (rs, rt):
  - EX/MEM match: reg_wr_mem_i=1, rd_addr_mem_i=addr, addr!=0 → use res_mem_i.
  - Otherwise MEM/WB match: same rule on the WB signals → use res_wb_i.
  - Otherwise use the registered value.
  - EX/MEM has priority over MEM/WB. Register $0 is never forwarded.
- opr_b_ex_o:
  - sel 0/3 → forwarded rt.
  - sel 1 → registered imm.
  - sel 2 → {27'b0, shamt}.
- st_data_ex_o is always the forwarded rt.
- Load-use hazard (combinational): stall_id_o=1 when all of the following hold:
  - valid_ex_o and mem_rd_ex_o are set, and rd_addr_ex_o!=0;
  - valid_id_i is set;
  - (use_rs_id_i and rs_addr_id_i==rd_addr_ex_o) or (use_rt_id_i and rt_addr_id_i==rd_addr_ex_o).
  - stall_id_o is forced to 1 whenever ex_stall_i=1.
- Register update priority per cycle:
  1. reset.
  2. flush_i → valid_ex=0; control cleared; data don't-care.
  3. ex_stall_i → hold. rs/rt data registers re-capture their forwarded values, so bypass sources may retire while held.
  4. load-use → bubble: valid_ex=0, controls cleared.
  5. Otherwise capture ID; valid_ex=valid_id_i.
- flush_i together with ex_stall_i: flush wins.
- Bubble and invalid entries never forward: downstream stages see reg_wr=0.

Optional Feature:
- Macro: ID_EX_HAZARD_STATS_EN.
- With the macro defined, two extra outputs are added:
  - fwd_cnt_o [15:0]: counts cycles with valid_ex_o and ≥1 operand forwarded.
  - lu_stall_cnt_o [15:0]: counts load-use bubbles inserted.
  - Both saturate at 16'hFFFF and are cleared by reset.
  - Neither counts while ex_stall_i=1.
- Without the macro, no ports, counters or logic exist.

Decomposition:
- Shared defines file alongside the existing ALU defines:
  - SRC_B_RT, SRC_B_IMM, SRC_B_SHAMT encodings.
  - FWD_NONE, FWD_MEM, FWD_WB select encodings.
- One sub-module, fwd_sel. It performs address compare plus priority mux for one operand and is instantiated twice (rs, rt).

Test Plan:
- No hazard: rs=5 (data 0x10), rt=6 (data 0x20), add, sel 0 → next cycle opr_a=0x10, opr_b=0x20, valid_ex=1, stall_id=0.
- Double forward: EX/MEM rd=5 res=0xAAAA, MEM/WB rd=5 res=0xBBBB → opr_a=0xAAAA. Remove EX/MEM match → opr_a=0xBBBB. rd=0 with res=0xDEAD → no forward.
- Load-use: EX holds lw to r8; ID reads r8 → stall_id=1 for one cycle, then EX valid=0 bubble, then the instruction enters with no stall.
- Hold refresh: ex_stall_i=1 for 3 cycles while MEM/WB forwards r9=0x1234 in the first cycle only → opr_a stays 0x1234 after release.
- Flush: flush_i=1 together with ex_stall_i=1 → valid_ex=0, reg_wr/mem_rd/mem_wr all 0 next cycle.
- Reset mid-stream: assert reset during a load-use stall → all outputs 0 next cycle, stall_id=0. With ID_EX_HAZARD_STATS_EN, both counters are 0.
